rom_sequence_ctrl: RTL

//  Picks which microcode program the decode-stage ROM block runs. Sits between the decoder and the ROM block.
//  Two requesters share the ROM: interrupt entry and decoder complex-op. The controller grants one.
//  It holds rom_control and rom_in_control stable for the whole program and retires on the last uop accepted.
//  A pipeline flush aborts the running program.

---
 rtl/rom_ctrl_pkg.sv | 18 +
 rtl/rom_ctrl_wdog.sv | 38 +++
 rtl/rom_sequence_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the decode-stage ROM sequence controller.
package rom_ctrl_pkg;

    localparam int PROG_W = 4;
    localparam int VEC_W  = 8;

    typedef logic [PROG_W-1:0] prog_t;
    typedef logic [VEC_W-1:0]  ivec_t;

    localparam prog_t PROG_NONE        = 4'd0;
    localparam prog_t INT_PROG_DEFAULT = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rom_ctrl_wdog.sv
// Stall watchdog for the ROM sequence controller; only built when ROM_CTRL_WDOG_EN is defined.
`ifdef ROM_CTRL_WDOG_EN
module rom_ctrl_wdog #(
    parameter int WDOG_CYCLES = 64,
    parameter int WDOG_W      = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The program is aborted at the limit, so the counter never wraps.
    assign expired_o = run_i && (count_q == WDOG_W'(WDOG_CYCLES - 1));

endmodule
`endif

// File: rtl/rom_sequence_ctrl.sv
// Arbitrates interrupt entry vs decoder complex-op for the microcode ROM and holds the program select.
// Optional stall watchdog enabled by defining ROM_CTRL_WDOG_EN.
module rom_sequence_ctrl
    import rom_ctrl_pkg::*;
#(
    parameter prog_t INT_PROG    = INT_PROG_DEFAULT,
    parameter int    WDOG_CYCLES = 64,
    parameter int    WDOG_W      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_req,
    input  logic [PROG_W-1:0] dec_prog,
    output logic              dec_gnt,
    input  logic              int_req,
    input  logic [VEC_W-1:0]  int_vec,
    output logic              int_gnt,
    input  logic              uop_accept,
    input  logic              uop_last,
    input  logic              flush,
    output logic [PROG_W-1:0] rom_control,
    output logic              rom_in_control,
    output logic [VEC_W-1:0]  int_vec_q,
    output logic              prog_done,
    output logic              wdog_err
);

    if (2 ** WDOG_W <= WDOG_CYCLES) begin : g_bad_wdog_w
        $error("WDOG_W too narrow for WDOG_CYCLES");
    end

    state_e state_q, state_d;
    prog_t  rom_control_q, rom_control_d;
    logic   rom_in_control_q;
    ivec_t  int_vec_q_q, int_vec_q_d;
    logic   wdog_fire;

`ifdef ROM_CTRL_WDOG_EN
    logic wdog_expired;

    rom_ctrl_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_W      (WDOG_W)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (int_gnt || dec_gnt || uop_accept),
        .run_i     (state_q == ST_RUN),
        .expired_o (wdog_expired)
    );

    assign wdog_fire = wdog_expired && !uop_accept;
`else
    assign wdog_fire = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        rom_control_d = rom_control_q;
        int_vec_q_d   = int_vec_q_q;
        int_gnt       = 1'b0;
        dec_gnt       = 1'b0;
        prog_done     = 1'b0;
        wdog_err      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!flush && !reset) begin
                    if (int_req) begin
                        int_gnt       = 1'b1;
                        state_d       = ST_RUN;
                        rom_control_d = INT_PROG;
                        int_vec_q_d   = int_vec;
                    end else if (dec_req && dec_prog != PROG_NONE) begin
                        dec_gnt       = 1'b1;
                        state_d       = ST_RUN;
                        rom_control_d = dec_prog;
                    end
                end
            end
            ST_RUN: begin
                // Flush outranks both normal retirement and a watchdog abort.
                if (flush) begin
                    state_d       = ST_IDLE;
                    rom_control_d = PROG_NONE;
                end else if (uop_accept && uop_last) begin
                    prog_done     = !reset;
                    state_d       = ST_IDLE;
                    rom_control_d = PROG_NONE;
                end else if (wdog_fire) begin
                    wdog_err      = !reset;
                    state_d       = ST_IDLE;
                    rom_control_d = PROG_NONE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                rom_control_d = PROG_NONE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            rom_control_q    <= PROG_NONE;
            rom_in_control_q <= 1'b0;
            int_vec_q_q      <= '0;
        end else begin
            state_q          <= state_d;
            rom_control_q    <= rom_control_d;
            rom_in_control_q <= |rom_control_d;
            int_vec_q_q      <= int_vec_q_d;
        end
    end

    assign rom_control    = rom_control_q;
    assign rom_in_control = rom_in_control_q;
    assign int_vec_q      = int_vec_q_q;

endmodule
